// File: rtl/muldiv_unit.sv
// muldiv_unit - iterative radix-2 RV32M multiply/divide unit for the EX stage.
//
// Multiplies with an MSB-first shift-add over a 2*XLEN-bit accumulator and
// divides with a restoring divider over an (XLEN+1)-bit partial remainder,
// one operand bit per cycle. Signed ops run on magnitudes, and the sign is
// fixed up in DONE just before the result is registered.
// Divide by zero and signed overflow finish directly without a RUN phase.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   start      operation request, honoured only in IDLE
//   funct3     RV32M op (000 MUL .. 111 REMU)
//   op_a, op_b forwarded rs1 / rs2 values
//   flush      abort the in-flight operation or drop the pending request
//   busy       high while iterating (RUN)
//   done       one-cycle completion pulse, result valid with it
//   result     product half, quotient or remainder; held until next completion
//
// Build option: define MULDIV_ZERO_SKIP_EN to make zero-operand multiplies
// and zero-dividend divides finish without a RUN phase.

module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Latched operation context
    logic [2:0]        fn_q;
    logic              a_neg_q, b_neg_q;
    logic [XLEN-1:0]   mag_a_q, mag_b_q;
    logic [CW-1:0]     cnt_q;
    logic              spec_q;
    logic [XLEN-1:0]   spec_val_q;

    // Iteration state
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN:0]     rem_q;
    logic [XLEN-1:0]   quot_q;

    // ------------------------------------------------------------------
    // Request decode (valid in IDLE)
    // ------------------------------------------------------------------
    logic            is_div, sign_a, sign_b, a_neg_in, b_neg_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in;
    logic            div_zero, div_ovf, zero_case, special_in;
    logic [XLEN-1:0] special_val;

    always_comb begin
        is_div   = funct3[2];
        // Signed: MULH both, MULHSU op_a only, DIV/REM both
        sign_a   = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        sign_b   = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        a_neg_in = sign_a & op_a[XLEN-1];
        b_neg_in = sign_b & op_b[XLEN-1];
        mag_a_in = a_neg_in ? ((~op_a) + XLEN'(1)) : op_a;
        mag_b_in = b_neg_in ? ((~op_b) + XLEN'(1)) : op_b;

        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
`ifdef MULDIV_ZERO_SKIP_EN
        zero_case = is_div ? ((op_a == '0) && (op_b != '0))
                           : ((op_a == '0) || (op_b == '0));
`else
        zero_case = 1'b0;
`endif
        special_in = div_zero || div_ovf || zero_case;

        // funct3[1] selects remainder for divides
        if (div_zero) begin
            special_val = funct3[1] ? op_a : '1;
        end else if (div_ovf) begin
            special_val = funct3[1] ? '0 : op_a;
        end else begin
            special_val = '0;
        end
    end

    // ------------------------------------------------------------------
    // One radix-2 iteration, indexed MSB-first by the down-counter
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_next;
    logic [XLEN+1:0]   rem_shift, rem_diff;
    logic [XLEN:0]     rem_next;
    logic              sub_ok;

    always_comb begin
        prod_next = {prod_q[2*XLEN-2:0], 1'b0};
        if (mag_b_q[cnt_q]) begin
            prod_next = prod_next + {{XLEN{1'b0}}, mag_a_q};
        end

        rem_shift = {rem_q, mag_a_q[cnt_q]};
        rem_diff  = rem_shift - {2'b00, mag_b_q};
        sub_ok    = ~rem_diff[XLEN+1];
        rem_next  = sub_ok ? rem_diff[XLEN:0] : rem_shift[XLEN:0];
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? ('0 - prod_q) : prod_q;
        quot_fix = (a_neg_q ^ b_neg_q) ? ('0 - quot_q) : quot_q;
        rem_fix  = a_neg_q ? ('0 - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];

        if (spec_q) begin
            final_res = spec_val_q;
        end else begin
            case (fn_q)
                3'b000:                 final_res = prod_fix[XLEN-1:0];
                3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
                3'b100, 3'b101:         final_res = quot_fix;
                default:                final_res = rem_fix;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!flush && start) begin
                    state_d = special_in ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // done/result are registered on the DONE cycle, so the pulse appears the
    // cycle after DONE and a flush in DONE still cancels it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fn_q       <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            prod_q     <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        fn_q       <= funct3;
                        a_neg_q    <= a_neg_in;
                        b_neg_q    <= b_neg_in;
                        mag_a_q    <= mag_a_in;
                        mag_b_q    <= mag_b_in;
                        cnt_q      <= CNT_LAST;
                        spec_q     <= special_in;
                        spec_val_q <= special_val;
                        prod_q     <= '0;
                        rem_q      <= '0;
                        quot_q     <= '0;
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        if (fn_q[2]) begin
                            rem_q         <= rem_next;
                            quot_q[cnt_q] <= sub_ok;
                        end else begin
                            prod_q <= prod_next;
                        end
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (!flush) begin
                        done   <= 1'b1;
                        result <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (XLEN=32): directed plan cases plus randomized
// operations against an arithmetic reference model, checked by a scoreboard
// monitor on each done pulse (result, start-to-done latency, busy cycles).
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [31:0] res;
        int          start_cyc;
        int          lat;
        int          bsy;
        logic [2:0]  f;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          ndone = 0;
    int          busy_cnt = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: RV32M semantics in plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb2, ub;
        logic [63:0] p;
        int          ia, ib;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ub  = longint'({32'h0, b});
        ia  = a;
        ib  = b;
        case (f)
            3'd0: begin p = sa * sb2; return p[31:0]; end
            3'd1: begin p = sa * sb2; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_ZERO_SKIP_EN
        if (!f[2] && (a == 0 || b == 0)) return 1;
        if (f[2] && a == 0) return 1;
`endif
        return 33;
    endfunction

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (start && !busy) busy_cnt = 0;
                if (busy) busy_cnt++;
                if (done) begin
                    ndone++;
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("result f=%0d", e.f), result, e.res);
                        chk($sformatf("latency f=%0d", e.f), 32'(cyc - e.start_cyc), 32'(e.lat));
                        chk($sformatf("busy_cycles f=%0d", e.f), 32'(busy_cnt), 32'(e.bsy));
                    end
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        if (push) begin
            e.res       = model(f, a, b);
            e.start_cyc = cyc + 1;
            e.lat       = exp_lat(f, a, b);
            e.bsy       = (e.lat == 1) ? 0 : 32;
            e.f         = f;
            sb.push_back(e);
            last_res = e.res;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        chk("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        @(posedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;

        // Directed plan cases
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1); drain();
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1); drain();
        issue(3'd3, 32'h8000_0000, 32'h8000_0000, 1); drain();
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); drain();
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1); drain();
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1); drain();
        issue(3'd5, 32'd100, 32'd7, 1); drain();
        issue(3'd7, 32'd100, 32'd7, 1); drain();
        issue(3'd4, 32'd5, 32'd0, 1); drain();
        issue(3'd7, 32'd5, 32'd0, 1); drain();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1); drain();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1); drain();

        // Flush 10 cycles into a DIVU
        issue(3'd5, 32'd123456, 32'd3, 0);
        repeat (8) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_result_held", result, last_res);
        d0 = ndone;
        repeat (40) @(posedge clk);
        chk("flush_no_done", 32'(ndone - d0), 32'd0);

        // Second start mid-RUN is ignored
        d0 = ndone;
        issue(3'd0, 32'd11, 32'd13, 1);
        repeat (5) @(posedge clk);
        #1 start = 1'b1; funct3 = 3'd0; op_a = 32'd99; op_b = 32'd99;
        @(posedge clk); #1 start = 1'b0;
        drain();
        repeat (40) @(posedge clk);
        chk("single_done", 32'(ndone - d0), 32'd1);

        // Asynchronous reset mid-RUN
        issue(3'd0, 32'd5, 32'd6, 0);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        #1 rst = 1'b0;
        last_res = '0;
        issue(3'd0, 32'd3, 32'd4, 1); drain();
        issue(3'd0, 32'd0, 32'd9, 1); drain();

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 1);
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the forwarded operands produced by the EX-stage 4:1 operand-select muxes.
- Returns the result to the EX-stage result path; the hazard unit uses the busy handshake to stall the pipeline.
- Radix-2: one operand bit processed per cycle, for both the shift-add multiply and the restoring divide.

Parameters:
XLEN, 32, operand/result width; must be >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request to begin an operation; sampled only in IDLE
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value after the forwarding mux
op_b  input  XLEN  rs2 value after the forwarding mux
flush  input  1  abort the in-flight operation (branch mispredict or trap)
busy  output  1  high while the operation is in RUN
done  output  1  one-cycle pulse; result valid in the same cycle
result  output  XLEN  selected product half, quotient, or remainder

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0; done=0; result=0; internal accumulators=0; counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches funct3, op_a and op_b, and computes operand magnitudes.
  - Operands are signed per op: MULH both; MULHSU op_a only; DIV/REM both; all others unsigned.
  - Goes to RUN with counter=XLEN-1.
  - start=0: remain in IDLE.
- RUN:
  - busy=1. One iteration per cycle; counter decrements.
  - Multiply: 2*XLEN-bit shift-add product.
  - Divide: restoring divide producing quotient and remainder.
  - After the iteration with counter=0, go to DONE.
  - Normal latency: start edge -> done high exactly XLEN+1 cycles later (33 for XLEN=32).
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Sign correction is applied before result is registered:
    - Product negated if the operand signs differ.
    - Quotient negated if the signs differ.
    - Remainder takes the sign of the dividend.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Next state: IDLE.
- result holds its value from DONE until the next completion or reset.
- start while busy (RUN or DONE) is ignored; the hazard unit must hold the instruction until the done pulse.
- Special cases, resolved in IDLE with no RUN: next cycle is DONE, so done comes 1 cycle after the start edge.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow, op_a = most-negative and op_b = -1: DIV = op_a; REM = 0.
- flush:
  - In RUN or DONE: next state IDLE, done suppressed, result unchanged.
  - In IDLE: takes priority over start; the request is dropped.
- Reset mid-operation: immediate return to the reset values; no done pulse.
- Iteration width rules:
  - The divide partial remainder is XLEN+1 bits; a subtract is accepted when its result is non-negative.
  - The multiply accumulator is 2*XLEN bits and carries no overflow.

Optional Feature:
- Macro: MULDIV_ZERO_SKIP_EN.
- Defined: a multiply with op_a=0 or op_b=0, or a divide with op_a=0 and op_b!=0, is a special case: result=0, done 1 cycle after the start edge, no RUN.
- Undefined: these cases take the full XLEN+1 cycle path and produce the same result value.
- Divide by zero is special-cased either way.

Test Plan:
- MUL op_a=7, op_b=-3 (0xFFFFFFFD) -> done 33 cycles after start, result=0xFFFFFFEB; busy high for exactly 32 cycles.
- MULH op_a=0x80000000, op_b=0x80000000 -> result=0x40000000. MULHU same operands -> 0x40000000. MULHSU op_a=-1, op_b=0xFFFFFFFF -> result=0xFFFFFFFF.
- DIV/REM, op_a=-7, op_b=2 -> DIV result=0xFFFFFFFD (-3), REM result=0xFFFFFFFF (-1). DIVU op_a=100, op_b=7 -> 14; REMU -> 2.
- Special cases, each with done 1 cycle after start:
  - DIV op_b=0, op_a=5 -> 0xFFFFFFFF.
  - REMU op_b=0, op_a=5 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Abort and ignore:
  - flush asserted 10 cycles into a DIVU -> no done pulse, busy falls next cycle, result keeps its previous value.
  - A second start pulsed mid-RUN -> ignored; exactly one done.
- rst pulsed asynchronously mid-RUN (between edges) -> busy/done/result go to 0 immediately. A new MUL 3*4 afterwards -> done after 33 cycles with result=12. With MULDIV_ZERO_SKIP_EN defined, MUL 0*9 -> done after 1 cycle, result=0.
